// File: rtl/reverse_stream_restore.sv
// Receive-side reorder buffer: undoes segment-reversed ordering of a 32-element
// coefficient stream and presents the restored vector on a valid/ready output.
//
// state | meaning
// IDLE  | waiting for element 0 of a vector, seg_log2 sampled on accept
// FILL  | collecting elements 1..31
// HOLD  | vector presented on out_vector until out_ready handshake

module reverse_stream_restore #(
  parameter int WIDTH = 16,
  parameter int NUM   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              seg_log2,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_vector [NUM-1:0],
  output logic                    err
);

  if (NUM != 32) begin : g_num_check
    $error("reverse_stream_restore: NUM must be 32");
  end

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t     state;
  logic [4:0] count;
  logic [2:0] seg_q;
  logic [2:0] seg_in;
  logic [2:0] seg_cur;
  logic [4:0] wr_pos;
  logic       accept;
  logic       last_elem;

  assign seg_in    = (seg_log2 > 3'd5) ? 3'd5 : seg_log2;
  assign seg_cur   = (state == IDLE) ? seg_in : seg_q;
  assign accept    = in_valid && in_ready;
  assign last_elem = (count == 5'd31);
  // Segment index bits are inverted, in-segment offset bits kept; self-inverse.
  assign wr_pos    = count ^ (5'h1f << seg_cur);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      seg_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < NUM; i++) out_vector[i] <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE, FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            out_vector[wr_pos] <= in_data;
            if (state == IDLE) seg_q <= seg_in;
            if (last_elem || in_last) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              count     <= '0;
              // Flags both an early in_last and a missing one at element 31.
              err       <= last_elem ^ in_last;
            end else begin
              state <= FILL;
              count <= count + 5'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            // Cleared so a short vector never exposes the previous one.
            for (int i = 0; i < NUM; i++) out_vector[i] <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reverse_stream_restore.sv
// Directed self-checking bench for reverse_stream_restore.
module tb_reverse_stream_restore;

  logic               clk = 1'b0;
  logic               rst;
  logic [2:0]         seg_log2;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_vector [31:0];
  logic               err;

  int n_cmp  = 0;
  int n_fail = 0;
  int err_seen = 0;
  int exp_v [32];

  reverse_stream_restore #(.WIDTH(16), .NUM(32)) dut (
    .clk(clk), .rst(rst), .seg_log2(seg_log2),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_vector(out_vector), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && err) err_seen++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s[%0d]", tag, i), int'(out_vector[i]), exp_v[i]);
  endtask

  // Expected restored vector: arrival k lands at 32-((k/n)+1)*n+(k%n).
  task automatic build(input int n, input int base, input int count);
    for (int i = 0; i < 32; i++) exp_v[i] = 0;
    for (int k = 0; k < count; k++) exp_v[32 - ((k / n) + 1) * n + (k % n)] = base + k;
  endtask

  task automatic send(input int d, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = 16'(d);
    in_last  = last;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("send_ready_timeout", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic stream(input int k0, input int k1, input int base, input int last_at);
    for (int k = k0; k <= k1; k++) send(base + k, k == last_at);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hs_out_valid", int'(out_valid), 0);
    chk("hs_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    rst = 1'b1; seg_log2 = 3'd0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_vec0", int'(out_vector[0]), 0);
    chk("rst_vec31", int'(out_vector[31]), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);

    // N=4, data=k
    seg_log2 = 3'd2;
    stream(0, 30, 0, 31);
    chk("n4_valid_early", int'(out_valid), 0);
    send(31, 1'b1);
    chk("n4_out_valid", int'(out_valid), 1);
    chk("n4_err", int'(err), 0);
    chk("n4_v0", int'(out_vector[0]), 28);
    chk("n4_v3", int'(out_vector[3]), 31);
    chk("n4_v28", int'(out_vector[28]), 0);
    chk("n4_v31", int'(out_vector[31]), 3);
    build(4, 0, 32);
    chk_vec("n4");

    // Backpressure with stray input traffic
    in_valid = 1'b1; in_data = 16'sd777; in_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_v0", int'(out_vector[0]), 28);
      chk("bp_v17", int'(out_vector[17]), 13);
    end
    in_valid = 1'b0; in_last = 1'b0;
    handshake();
    build(4, 0, 0);
    chk_vec("cleared");

    // Identity (N=32), seg_log2 changed mid-vector must be ignored
    seg_log2 = 3'd5;
    stream(0, 5, -100, 31);
    seg_log2 = 3'd0;
    stream(6, 31, -100, 31);
    build(32, -100, 32);
    chk_vec("ident");
    chk("ident_v0", int'(out_vector[0]), -100);
    handshake();

    // Full reversal (N=1)
    seg_log2 = 3'd0;
    stream(0, 31, -100, 31);
    chk("rev_v31", int'(out_vector[31]), -100);
    chk("rev_v0", int'(out_vector[0]), -69);
    build(1, -100, 32);
    chk_vec("rev");
    handshake();

    // Early in_last at element 9, N=8, data=k+1
    seg_log2 = 3'd3;
    stream(0, 9, 1, 9);
    chk("early_err", int'(err), 1);
    chk("early_valid", int'(out_valid), 1);
    chk("early_v24", int'(out_vector[24]), 1);
    chk("early_v31", int'(out_vector[31]), 8);
    chk("early_v16", int'(out_vector[16]), 9);
    chk("early_v17", int'(out_vector[17]), 10);
    chk("early_v18", int'(out_vector[18]), 0);
    build(8, 1, 10);
    chk_vec("early");
    @(posedge clk);
    #1;
    chk("early_err_pulse", int'(err), 0);
    chk("early_err_count", err_seen, 1);
    handshake();

    // Missing in_last at element 31, N=8
    seg_log2 = 3'd3;
    stream(0, 31, 500, 99);
    chk("miss_err", int'(err), 1);
    chk("miss_valid", int'(out_valid), 1);
    build(8, 500, 32);
    chk_vec("miss");
    @(posedge clk);
    #1;
    chk("miss_err_pulse", int'(err), 0);
    chk("miss_err_count", err_seen, 2);
    handshake();

    // Reset mid-vector, then a clean N=8 vector
    seg_log2 = 3'd3;
    stream(0, 19, 40, 31);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_v31", int'(out_vector[31]), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_in_ready_after", int'(in_ready), 1);
    stream(0, 31, -3000, 31);
    chk("clean_valid", int'(out_valid), 1);
    chk("clean_err", int'(err), 0);
    build(8, -3000, 32);
    chk_vec("clean");
    handshake();
    chk("final_err_count", err_seen, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
